// File: rtl/write_ptr_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: binary/Gray write
// pointer, registered full/almost_full/occupancy and a sticky overflow flag.
module write_ptr_ctrl #(
    parameter int fifo_depth         = 16,
    parameter int almost_full_thresh = 2,
    localparam int AW                = $clog2(fifo_depth)
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic          wen,
    input  logic [AW:0]   readaddrptrgreysync,
    input  logic          clr_overflow,
    output logic          wr_accept,
    output logic [AW-1:0] writeaddr,
    output logic [AW:0]   writeaddrptrgrey,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   wr_count,
    output logic          overflow
);

    localparam logic [AW:0] AF_LEVEL = (AW+1)'(fifo_depth - almost_full_thresh);

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] count_q, count_d;
    logic        full_q, full_d;
    logic        almost_full_q, almost_full_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] rbin;
    logic [AW:0] full_gray;

    assign wr_accept = wen && !full_q;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(readaddrptrgreysync >> i);
        end
    end

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_gray = {~readaddrptrgreysync[AW:AW-1], readaddrptrgreysync[AW-2:0]};

    always_comb begin
        wbin_d        = wbin_q + {{AW{1'b0}}, wr_accept};
        wgray_d       = (wbin_d >> 1) ^ wbin_d;
        count_d       = wbin_d - rbin;
        full_d        = (wgray_d == full_gray);
        almost_full_d = (count_d >= AF_LEVEL);
        overflow_d    = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (wen && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wgray_q       <= wgray_d;
            count_q       <= count_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign writeaddr        = wbin_q[AW-1:0];
    assign writeaddrptrgrey = wgray_q;
    assign full             = full_q;
    assign almost_full      = almost_full_q;
    assign wr_count         = count_q;
    assign overflow         = overflow_q;

endmodule
